// File: rtl/multi_port_biu.sv
// multi_port_biu: arbitrates NPORT requestor ports onto a memory bus and a
// peripheral bus, one outstanding transfer at a time.
// Ports:
//   clk_i, rst_i             clock, synchronous active-low reset
//   req_*_i                  per-port request (en, addr, data, wr, type, signed)
//   rsp_data_o/ready_o/err_o registered completion (one-cycle pulse on ready/err)
//   bus_mem_* / bus_per_*    strobe/we/adr/dat/sel out, dat/ack in, per bus
module multi_port_biu #(
    parameter int unsigned NPORT     = 3,
    parameter int unsigned TMO       = 255,
    parameter logic [31:0] PER_MASK  = 32'hF000_0000,
    parameter logic [31:0] PER_MATCH = 32'h1000_0000
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NPORT-1:0]      req_en_i,
    input  logic [32*NPORT-1:0]   req_addr_i,
    input  logic [32*NPORT-1:0]   req_data_i,
    input  logic [NPORT-1:0]      req_wr_i,
    input  logic [2*NPORT-1:0]    req_type_i,
    input  logic [NPORT-1:0]      req_signed_i,
    output logic [31:0]           rsp_data_o,
    output logic [NPORT-1:0]      rsp_ready_o,
    output logic [NPORT-1:0]      rsp_err_o,
    output logic                  bus_mem_stb_o,
    output logic                  bus_mem_we_o,
    output logic [31:0]           bus_mem_adr_o,
    output logic [31:0]           bus_mem_dat_o,
    output logic [3:0]            bus_mem_sel_o,
    input  logic [31:0]           bus_mem_dat_i,
    input  logic                  bus_mem_ack_i,
    output logic                  bus_per_stb_o,
    output logic                  bus_per_we_o,
    output logic [31:0]           bus_per_adr_o,
    output logic [31:0]           bus_per_dat_o,
    output logic [3:0]            bus_per_sel_o,
    input  logic [31:0]           bus_per_dat_i,
    input  logic                  bus_per_ack_i
);

    localparam int unsigned PW = (NPORT > 1) ? $clog2(NPORT) : 1;
    localparam int unsigned CW = 8;
    localparam logic [NPORT-1:0] PORT0 = {{(NPORT-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   last_q, last_d, gnt_q, gnt_d;
    logic [1:0]      lane_q, lane_d, type_q, type_d;
    logic            signed_q, signed_d, wr_q, wr_d, per_q, per_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic            mem_stb_d, mem_we_d, per_stb_d, per_we_d;
    logic [31:0]     mem_adr_d, mem_dat_d, per_adr_d, per_dat_d, rsp_data_d;
    logic [3:0]      mem_sel_d, per_sel_d;
    logic [NPORT-1:0] rsp_ready_d, rsp_err_d;

    // Round-robin pick, searching upward from the port after the last grant
    int unsigned     cand;
    logic            pick_found, pick_wr, pick_signed;
    logic [PW-1:0]   pick_idx;
    logic [31:0]     pick_addr, pick_data;
    logic [1:0]      pick_type;

    always_comb begin
        cand        = 0;
        pick_found  = 1'b0;
        pick_idx    = '0;
        pick_addr   = '0;
        pick_data   = '0;
        pick_wr     = 1'b0;
        pick_type   = '0;
        pick_signed = 1'b0;
        for (int unsigned i = 1; i <= NPORT; i++) begin
            cand = (32'(last_q) + i) % NPORT;
            if (!pick_found && req_en_i[cand]) begin
                pick_found  = 1'b1;
                pick_idx    = PW'(cand);
                pick_addr   = req_addr_i[32*cand +: 32];
                pick_data   = req_data_i[32*cand +: 32];
                pick_wr     = req_wr_i[cand];
                pick_type   = req_type_i[2*cand +: 2];
                pick_signed = req_signed_i[cand];
            end
        end
    end

    // Decode of the picked request: alignment, lanes, write-data placement, target
    logic        pick_mis, pick_per;
    logic [3:0]  pick_sel;
    logic [31:0] pick_wdat;

    always_comb begin
        pick_per = (pick_addr & PER_MASK) == PER_MATCH;
        case (pick_type)
            2'b01: begin
                pick_mis  = 1'b0;
                pick_sel  = 4'b0001 << pick_addr[1:0];
                pick_wdat = {4{pick_data[7:0]}};
            end
            2'b10: begin
                pick_mis  = pick_addr[0];
                pick_sel  = pick_addr[1] ? 4'b1100 : 4'b0011;
                pick_wdat = {2{pick_data[15:0]}};
            end
            default: begin
                pick_mis  = pick_addr[1:0] != 2'b00;
                pick_sel  = 4'b1111;
                pick_wdat = pick_data;
            end
        endcase
    end

    // Read-data alignment to bit 0 with zero/sign extension
    logic        ack;
    logic [31:0] rd_raw, rd_ext;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    always_comb begin
        ack     = per_q ? bus_per_ack_i : bus_mem_ack_i;
        rd_raw  = per_q ? bus_per_dat_i : bus_mem_dat_i;
        rd_byte = rd_raw[{lane_q, 3'b000} +: 8];
        rd_half = lane_q[1] ? rd_raw[31:16] : rd_raw[15:0];
        case (type_q)
            2'b01:   rd_ext = signed_q ? {{24{rd_byte[7]}}, rd_byte} : {24'h0, rd_byte};
            2'b10:   rd_ext = signed_q ? {{16{rd_half[15]}}, rd_half} : {16'h0, rd_half};
            default: rd_ext = rd_raw;
        endcase
    end

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        gnt_d       = gnt_q;
        lane_d      = lane_q;
        type_d      = type_q;
        signed_d    = signed_q;
        wr_d        = wr_q;
        per_d       = per_q;
        cnt_d       = cnt_q;
        mem_stb_d   = bus_mem_stb_o;
        mem_we_d    = bus_mem_we_o;
        mem_adr_d   = bus_mem_adr_o;
        mem_dat_d   = bus_mem_dat_o;
        mem_sel_d   = bus_mem_sel_o;
        per_stb_d   = bus_per_stb_o;
        per_we_d    = bus_per_we_o;
        per_adr_d   = bus_per_adr_o;
        per_dat_d   = bus_per_dat_o;
        per_sel_d   = bus_per_sel_o;
        rsp_data_d  = rsp_data_o;
        rsp_ready_d = '0;
        rsp_err_d   = '0;

        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    gnt_d    = pick_idx;
                    last_d   = pick_idx;
                    lane_d   = pick_addr[1:0];
                    type_d   = pick_type;
                    signed_d = pick_signed;
                    wr_d     = pick_wr;
                    per_d    = pick_per;
                    cnt_d    = '0;
                    if (pick_mis) begin
                        // Misaligned: report error without touching either bus
                        state_d     = RESP;
                        rsp_ready_d = PORT0 << pick_idx;
                        rsp_err_d   = PORT0 << pick_idx;
                        rsp_data_d  = '0;
                    end else begin
                        state_d = BUSY;
                        if (pick_per) begin
                            per_stb_d = 1'b1;
                            per_we_d  = pick_wr;
                            per_adr_d = pick_addr;
                            per_dat_d = pick_wdat;
                            per_sel_d = pick_sel;
                        end else begin
                            mem_stb_d = 1'b1;
                            mem_we_d  = pick_wr;
                            mem_adr_d = pick_addr;
                            mem_dat_d = pick_wdat;
                            mem_sel_d = pick_sel;
                        end
                    end
                end
            end
            BUSY: begin
                // Ack wins over a timeout landing in the same cycle
                if (ack || cnt_q == CW'(TMO - 1)) begin
                    state_d     = RESP;
                    rsp_ready_d = PORT0 << gnt_q;
                    mem_stb_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_adr_d   = '0;
                    mem_dat_d   = '0;
                    mem_sel_d   = '0;
                    per_stb_d   = 1'b0;
                    per_we_d    = 1'b0;
                    per_adr_d   = '0;
                    per_dat_d   = '0;
                    per_sel_d   = '0;
                    if (ack) begin
                        rsp_data_d = wr_q ? 32'h0 : rd_ext;
                    end else begin
                        rsp_err_d  = PORT0 << gnt_q;
                        rsp_data_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q       <= IDLE;
            last_q        <= PW'(NPORT - 1);
            gnt_q         <= '0;
            lane_q        <= '0;
            type_q        <= '0;
            signed_q      <= 1'b0;
            wr_q          <= 1'b0;
            per_q         <= 1'b0;
            cnt_q         <= '0;
            bus_mem_stb_o <= 1'b0;
            bus_mem_we_o  <= 1'b0;
            bus_mem_adr_o <= '0;
            bus_mem_dat_o <= '0;
            bus_mem_sel_o <= '0;
            bus_per_stb_o <= 1'b0;
            bus_per_we_o  <= 1'b0;
            bus_per_adr_o <= '0;
            bus_per_dat_o <= '0;
            bus_per_sel_o <= '0;
            rsp_data_o    <= '0;
            rsp_ready_o   <= '0;
            rsp_err_o     <= '0;
        end else begin
            state_q       <= state_d;
            last_q        <= last_d;
            gnt_q         <= gnt_d;
            lane_q        <= lane_d;
            type_q        <= type_d;
            signed_q      <= signed_d;
            wr_q          <= wr_d;
            per_q         <= per_d;
            cnt_q         <= cnt_d;
            bus_mem_stb_o <= mem_stb_d;
            bus_mem_we_o  <= mem_we_d;
            bus_mem_adr_o <= mem_adr_d;
            bus_mem_dat_o <= mem_dat_d;
            bus_mem_sel_o <= mem_sel_d;
            bus_per_stb_o <= per_stb_d;
            bus_per_we_o  <= per_we_d;
            bus_per_adr_o <= per_adr_d;
            bus_per_dat_o <= per_dat_d;
            bus_per_sel_o <= per_sel_d;
            rsp_data_o    <= rsp_data_d;
            rsp_ready_o   <= rsp_ready_d;
            rsp_err_o     <= rsp_err_d;
        end
    end

endmodule

// File: tb/tb_multi_port_biu.sv
// Self-checking bench for multi_port_biu (NPORT=3, TMO=4): directed cases
// followed by randomized transfers checked against a behavioural model.
module tb_multi_port_biu;

    localparam int unsigned NP    = 3;
    localparam int unsigned TMO_T = 4;

    logic             clk = 1'b0;
    logic             rst_i;
    logic [NP-1:0]    req_en_i, req_wr_i, req_signed_i;
    logic [32*NP-1:0] req_addr_i, req_data_i;
    logic [2*NP-1:0]  req_type_i;
    logic [31:0]      rsp_data_o;
    logic [NP-1:0]    rsp_ready_o, rsp_err_o;
    logic             bus_mem_stb_o, bus_mem_we_o, bus_mem_ack_i;
    logic [31:0]      bus_mem_adr_o, bus_mem_dat_o, bus_mem_dat_i;
    logic [3:0]       bus_mem_sel_o;
    logic             bus_per_stb_o, bus_per_we_o, bus_per_ack_i;
    logic [31:0]      bus_per_adr_o, bus_per_dat_o, bus_per_dat_i;
    logic [3:0]       bus_per_sel_o;

    always #5 clk = ~clk;

    multi_port_biu #(
        .NPORT(NP), .TMO(TMO_T), .PER_MASK(32'hF000_0000), .PER_MATCH(32'h1000_0000)
    ) dut (
        .clk_i(clk), .rst_i(rst_i),
        .req_en_i(req_en_i), .req_addr_i(req_addr_i), .req_data_i(req_data_i),
        .req_wr_i(req_wr_i), .req_type_i(req_type_i), .req_signed_i(req_signed_i),
        .rsp_data_o(rsp_data_o), .rsp_ready_o(rsp_ready_o), .rsp_err_o(rsp_err_o),
        .bus_mem_stb_o(bus_mem_stb_o), .bus_mem_we_o(bus_mem_we_o),
        .bus_mem_adr_o(bus_mem_adr_o), .bus_mem_dat_o(bus_mem_dat_o),
        .bus_mem_sel_o(bus_mem_sel_o), .bus_mem_dat_i(bus_mem_dat_i),
        .bus_mem_ack_i(bus_mem_ack_i),
        .bus_per_stb_o(bus_per_stb_o), .bus_per_we_o(bus_per_we_o),
        .bus_per_adr_o(bus_per_adr_o), .bus_per_dat_o(bus_per_dat_o),
        .bus_per_sel_o(bus_per_sel_o), .bus_per_dat_i(bus_per_dat_i),
        .bus_per_ack_i(bus_per_ack_i)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int last_model;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---- behavioural model: transfer size in bytes drives every rule ----
    function automatic int size_of(input logic [1:0] t);
        return (t == 2'b01) ? 1 : (t == 2'b10) ? 2 : 4;
    endfunction

    function automatic bit m_mis(input logic [31:0] a, input logic [1:0] t);
        return (int'(a[1:0]) % size_of(t)) != 0;
    endfunction

    function automatic bit m_per(input logic [31:0] a);
        return (a & 32'hF000_0000) == 32'h1000_0000;
    endfunction

    function automatic logic [3:0] m_sel(input logic [31:0] a, input logic [1:0] t);
        int s;
        s = ((1 << size_of(t)) - 1) << int'(a[1:0]);
        return 4'(s);
    endfunction

    function automatic logic [31:0] m_wdata(input logic [31:0] d, input logic [1:0] t);
        int sz;
        logic [31:0] unit, r;
        sz   = size_of(t);
        unit = 32'(longint'(d) % (longint'(1) << (8 * sz)));
        r    = '0;
        for (int k = 0; k < 4 / sz; k++) r = r | (unit << (8 * sz * k));
        return r;
    endfunction

    function automatic logic [31:0] m_rdata(input logic [31:0] bus, input logic [31:0] a,
                                            input logic [1:0] t, input logic sgn);
        longint full, v;
        full = longint'(1) << (8 * size_of(t));
        v    = (longint'(bus) >> (8 * int'(a[1:0]))) % full;
        if (sgn && v >= full / 2) v = v - full;
        return 32'(v);
    endfunction

    function automatic logic [NP-1:0] onehot(input int p);
        logic [NP-1:0] r;
        r = '0;
        r[p] = 1'b1;
        return r;
    endfunction

    // One single-port transfer; called and returns at a falling edge with the DUT idle
    task automatic xfer(input int port, input logic [31:0] addr, input logic [31:0] data,
                        input logic wr, input logic [1:0] t, input logic sgn,
                        input int ack_delay, input logic [31:0] bdat, input bit drop,
                        input bit noise, output logic [3:0] o_sel,
                        output logic [31:0] o_dat, output logic [31:0] o_rsp);
        bit per, acked;
        logic [NP-1:0] oh;
        logic [31:0] exp_rsp;
        logic ack_now;
        per   = m_per(addr);
        oh    = onehot(port);
        o_sel = '0;
        o_dat = '0;
        req_en_i   = oh;
        req_addr_i = '0; req_addr_i[32*port +: 32] = addr;
        req_data_i = '0; req_data_i[32*port +: 32] = data;
        req_type_i = '0; req_type_i[2*port +: 2] = t;
        req_wr_i     = wr  ? oh : '0;
        req_signed_i = sgn ? oh : '0;
        last_model = port;
        @(negedge clk);
        if (drop) req_en_i = '0;
        if (m_mis(addr, t)) begin
            chk("mis_mem_stb", 32'(bus_mem_stb_o), 0);
            chk("mis_per_stb", 32'(bus_per_stb_o), 0);
            chk("mis_ready", 32'(rsp_ready_o), 32'(oh));
            chk("mis_err", 32'(rsp_err_o), 32'(oh));
            chk("mis_rsp_data", rsp_data_o, 0);
        end else begin
            acked = 1'b0;
            for (int c = 0; c < int'(TMO_T); c++) begin
                chk("stb_target", 32'(per ? bus_per_stb_o : bus_mem_stb_o), 1);
                chk("stb_other", 32'(per ? bus_mem_stb_o : bus_per_stb_o), 0);
                chk("adr", per ? bus_per_adr_o : bus_mem_adr_o, addr);
                chk("sel", 32'(per ? bus_per_sel_o : bus_mem_sel_o), 32'(m_sel(addr, t)));
                chk("we", 32'(per ? bus_per_we_o : bus_mem_we_o), 32'(wr));
                if (wr) chk("wdat", per ? bus_per_dat_o : bus_mem_dat_o, m_wdata(data, t));
                chk("other_bus_quiet", per ? {bus_mem_adr_o[27:0], bus_mem_sel_o}
                                           : {bus_per_adr_o[27:0], bus_per_sel_o}, 0);
                chk("other_we", 32'(per ? bus_mem_we_o : bus_per_we_o), 0);
                if (c == 0) begin
                    o_sel = per ? bus_per_sel_o : bus_mem_sel_o;
                    o_dat = per ? bus_per_dat_o : bus_mem_dat_o;
                end
                ack_now = (c == ack_delay);
                if (per) begin
                    bus_per_ack_i = ack_now; bus_per_dat_i = ack_now ? bdat : $urandom;
                    bus_mem_ack_i = noise ? 1'($urandom) : 1'b0; bus_mem_dat_i = $urandom;
                end else begin
                    bus_mem_ack_i = ack_now; bus_mem_dat_i = ack_now ? bdat : $urandom;
                    bus_per_ack_i = noise ? 1'($urandom) : 1'b0; bus_per_dat_i = $urandom;
                end
                @(negedge clk);
                bus_mem_ack_i = 1'b0;
                bus_per_ack_i = 1'b0;
                if (ack_now) begin
                    acked = 1'b1;
                    break;
                end
            end
            exp_rsp = (acked && !wr) ? m_rdata(bdat, addr, t, sgn) : 32'h0;
            chk("ready", 32'(rsp_ready_o), 32'(oh));
            chk("err", 32'(rsp_err_o), acked ? 32'h0 : 32'(oh));
            chk("rsp_data", rsp_data_o, exp_rsp);
            chk("stb_off_in_resp", 32'({bus_mem_stb_o, bus_per_stb_o}), 0);
        end
        o_rsp    = rsp_data_o;
        req_en_i = '0;
        @(negedge clk);
        chk("ready_pulse_end", 32'(rsp_ready_o), 0);
        chk("err_pulse_end", 32'(rsp_err_o), 0);
        chk("stb_idle", 32'({bus_mem_stb_o, bus_per_stb_o}), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  o_sel;
        logic [31:0] o_dat, o_rsp, d, a;
        logic [NP-1:0] mask;
        int exp_order [6];
        int exp_p;
        bit found;
        exp_order = '{0, 1, 2, 0, 1, 2};

        rst_i = 1'b0;
        req_en_i = '0; req_wr_i = '0; req_signed_i = '0;
        req_addr_i = '0; req_data_i = '0; req_type_i = '0;
        bus_mem_ack_i = 1'b0; bus_mem_dat_i = '0;
        bus_per_ack_i = 1'b0; bus_per_dat_i = '0;
        repeat (3) @(negedge clk);
        chk("rst_stb", 32'({bus_mem_stb_o, bus_per_stb_o}), 0);
        chk("rst_we", 32'({bus_mem_we_o, bus_per_we_o}), 0);
        chk("rst_adr", bus_mem_adr_o | bus_per_adr_o, 0);
        chk("rst_dat", bus_mem_dat_o | bus_per_dat_o, 0);
        chk("rst_sel", 32'({bus_mem_sel_o, bus_per_sel_o}), 0);
        chk("rst_ready", 32'(rsp_ready_o), 0);
        chk("rst_err", 32'(rsp_err_o), 0);
        chk("rst_rsp_data", rsp_data_o, 0);
        rst_i = 1'b1;
        last_model = NP - 1;

        // Word read, immediate ack
        xfer(0, 32'h0000_0010, 32'h0, 1'b0, 2'b00, 1'b0, 0, 32'hDEAD_BEEF, 1'b0, 1'b0,
             o_sel, o_dat, o_rsp);
        chk("word_read_sel", 32'(o_sel), 32'hF);
        chk("word_read_data", o_rsp, 32'hDEAD_BEEF);

        // Signed byte read on the peripheral bus
        xfer(1, 32'h1000_0003, 32'h0, 1'b0, 2'b01, 1'b1, 0, 32'h8000_0000, 1'b0, 1'b1,
             o_sel, o_dat, o_rsp);
        chk("sbyte_sel", 32'(o_sel), 32'h8);
        chk("sbyte_data", o_rsp, 32'hFFFF_FF80);

        // Half write to upper half, request dropped after grant
        xfer(2, 32'h0000_0002, 32'h0000_ABCD, 1'b1, 2'b10, 1'b0, 1, 32'h1234_5678, 1'b1, 1'b0,
             o_sel, o_dat, o_rsp);
        chk("hwrite_sel", 32'(o_sel), 32'hC);
        chk("hwrite_dat", o_dat, 32'hABCD_ABCD);
        chk("hwrite_rsp", o_rsp, 32'h0);

        // Misaligned word
        xfer(0, 32'h0000_0001, 32'h0, 1'b0, 2'b00, 1'b0, 0, 32'h0, 1'b0, 1'b0,
             o_sel, o_dat, o_rsp);

        // Timeout: never acked
        xfer(1, 32'h0000_0040, 32'h0, 1'b0, 2'b00, 1'b0, 100, 32'h5555_AAAA, 1'b0, 1'b1,
             o_sel, o_dat, o_rsp);
        chk("timeout_rsp", o_rsp, 32'h0);

        // Reset during BUSY, then a late ack
        req_en_i = 3'b001; req_addr_i = '0; req_addr_i[31:0] = 32'h0000_0020;
        req_type_i = '0; req_wr_i = '0; req_signed_i = '0;
        @(negedge clk);
        chk("rstmid_stb", 32'(bus_mem_stb_o), 1);
        rst_i = 1'b0; req_en_i = '0;
        @(negedge clk);
        chk("rstmid_stb_off", 32'({bus_mem_stb_o, bus_per_stb_o}), 0);
        chk("rstmid_adr", bus_mem_adr_o, 0);
        chk("rstmid_ready", 32'(rsp_ready_o), 0);
        rst_i = 1'b1; bus_mem_ack_i = 1'b1; bus_mem_dat_i = $urandom;
        @(negedge clk);
        bus_mem_ack_i = 1'b0;
        chk("late_ack_ready", 32'(rsp_ready_o), 0);
        chk("late_ack_err", 32'(rsp_err_o), 0);
        chk("late_ack_data", rsp_data_o, 0);
        chk("late_ack_stb", 32'({bus_mem_stb_o, bus_per_stb_o}), 0);
        last_model = NP - 1;

        // All ports requesting continuously: grant order after reset
        req_en_i = 3'b111; req_type_i = '0; req_wr_i = '0; req_signed_i = '0;
        for (int p = 0; p < int'(NP); p++) req_addr_i[32*p +: 32] = 32'h100 + 32'(16 * p);
        for (int i = 0; i < 6; i++) begin
            found = 1'b0;
            for (int w = 0; w < 6; w++) begin
                @(negedge clk);
                if (bus_mem_stb_o) begin found = 1'b1; break; end
            end
            chk("rr_stb_seen", 32'(found), 1);
            if (!found) break;
            chk("rr_adr", bus_mem_adr_o, 32'h100 + 32'(16 * exp_order[i]));
            d = $urandom;
            bus_mem_ack_i = 1'b1; bus_mem_dat_i = d;
            @(negedge clk);
            bus_mem_ack_i = 1'b0;
            chk("rr_ready", 32'(rsp_ready_o), 32'(onehot(exp_order[i])));
            chk("rr_data", rsp_data_o, d);
            last_model = exp_order[i];
        end
        req_en_i = '0;
        @(negedge clk);

        // Random request masks: round-robin pick from the model
        for (int it = 0; it < 20; it++) begin
            mask = 3'($urandom_range(1, 7));
            exp_p = -1;
            for (int k = 1; k <= int'(NP); k++)
                if (exp_p < 0 && mask[(last_model + k) % NP]) exp_p = (last_model + k) % NP;
            req_en_i = mask;
            @(negedge clk);
            chk("arb_stb", 32'(bus_mem_stb_o), 1);
            chk("arb_adr", bus_mem_adr_o, 32'h100 + 32'(16 * exp_p));
            d = $urandom;
            bus_mem_ack_i = 1'b1; bus_mem_dat_i = d;
            @(negedge clk);
            bus_mem_ack_i = 1'b0; req_en_i = '0;
            chk("arb_ready", 32'(rsp_ready_o), 32'(onehot(exp_p)));
            chk("arb_data", rsp_data_o, d);
            last_model = exp_p;
            @(negedge clk);
            chk("arb_ready_end", 32'(rsp_ready_o), 0);
        end

        // Random single-port transfers of every type, target, alignment and ack delay
        for (int it = 0; it < 60; it++) begin
            a = $urandom;
            if ($urandom_range(0, 1) == 1) a = {4'h1, a[27:0]};
            xfer(int'($urandom_range(0, NP - 1)), a, $urandom, 1'($urandom), 2'($urandom),
                 1'($urandom), int'($urandom_range(0, 5)), $urandom, 1'($urandom),
                 1'($urandom), o_sel, o_dat, o_rsp);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
